// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_AW      = 5;
  localparam int MUL_LAT_MIN = 2;
  localparam int MUL_LAT_MAX = 16;
  localparam int CNT_BITS    = 4;

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    MUL_DONE
  } state_t;

  function automatic bit mul_lat_legal(input int lat);
    return (lat >= MUL_LAT_MIN) && (lat <= MUL_LAT_MAX);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX-side hazard inputs and the stall/flush enables returned to the pipeline.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  import hazard_pkg::*;

  logic [REG_AW-1:0] IdRs;
  logic [REG_AW-1:0] IdRt;
  logic              IdUsesRt;
  logic              IdBranchTaken;
  logic              ExMemRead;
  logic [REG_AW-1:0] ExRt;
  logic              ExMul;

  logic              PcWrite;
  logic              IfIdWrite;
  logic              IfIdFlush;
  logic              IdExWrite;
  logic              IdExFlush;
  logic              ExMemFlush;
  logic              MulBusy;
  logic [CNT_W-1:0]  StallCycles;

  // Pipeline side: supplies the ID/EX fields, consumes the enables.
  modport master (
    output IdRs, IdRt, IdUsesRt, IdBranchTaken, ExMemRead, ExRt, ExMul,
    input  PcWrite, IfIdWrite, IfIdFlush, IdExWrite, IdExFlush, ExMemFlush,
           MulBusy, StallCycles
  );

  modport slave (
    input  IdRs, IdRt, IdUsesRt, IdBranchTaken, ExMemRead, ExRt, ExMul,
    output PcWrite, IfIdWrite, IfIdFlush, IdExWrite, IdExFlush, ExMemFlush,
           MulBusy, StallCycles
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use, multi-cycle multiply and taken-branch hazard control beside ID/EX.
// Control outputs are Mealy; only state, cnt and the stall counter are flops.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  if (!mul_lat_legal(MUL_LAT)) begin : g_bad_mul_lat
    $error("hazard_ctrl: MUL_LAT must be within 2..16");
  end

  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'((MUL_LAT >= 3) ? MUL_LAT - 3 : 0);

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic                raw_hit, mul_hold, load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Only IDLE can start a multiply; in MUL_DONE the held multiply is still in EX.
  assign mul_hold = ((state == IDLE) && bus.ExMul) || (state == MUL_WAIT);
  assign raw_hit  = bus.ExMemRead && (bus.ExRt != '0) &&
                    ((bus.ExRt == bus.IdRs) || (bus.IdUsesRt && (bus.ExRt == bus.IdRt)));
  assign load_use = raw_hit && !mul_hold;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.ExMul) begin
          if (MUL_LAT >= 3) begin
            state_nxt = MUL_WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = MUL_DONE;
          end
        end
      end
      MUL_WAIT: begin
        if (cnt == '0) state_nxt = MUL_DONE;
        else           cnt_nxt   = cnt - CNT_BITS'(1);
      end
      MUL_DONE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.PcWrite    = 1'b1;
    bus.IfIdWrite  = 1'b1;
    bus.IfIdFlush  = 1'b0;
    bus.IdExWrite  = 1'b1;
    bus.IdExFlush  = 1'b0;
    bus.ExMemFlush = 1'b0;
    bus.MulBusy    = 1'b0;
    // Reset forces defaults combinationally so a mid-multiply reset releases at once.
    if (rst) begin
      if (mul_hold) begin
        bus.PcWrite    = 1'b0;
        bus.IfIdWrite  = 1'b0;
        bus.IdExWrite  = 1'b0;
        bus.ExMemFlush = 1'b1;
        bus.MulBusy    = 1'b1;
      end else if (load_use) begin
        bus.PcWrite   = 1'b0;
        bus.IfIdWrite = 1'b0;
        bus.IdExFlush = 1'b1;
      end else begin
        bus.IfIdFlush = bus.IdBranchTaken;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~bus.PcWrite),
    .count (bus.StallCycles)
  );

endmodule
